// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD : default geometry
//   state_t                              : controller states (INIT clears, RUN serves)
package reg_file_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_mp_bank.sv
// One copy of the register storage with a single write port and a single
// read port that holds its last captured index.
// Optional macro REG_FILE_MP_BYPASS_EN: write-first forwarding when the
// read index equals the index written at the same edge.
// Ports:
//   clk, resetn  : clock, asynchronous active-high reset (read side only)
//   clear        : forces read data to zero (controller clear sweep)
//   we/waddr/wdata : write port, committed on the rising edge
//   rd_en/rd_reg : capture a new read index; otherwise the held one is used
//   rd_data      : registered read data, one cycle after capture
module reg_file_mp_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_reg,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage is never reset; the controller clear sweep zeroes it.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rd_idx_p0;
  logic [DATA_W-1:0] rd_val_p0;
  logic [ADDR_W-1:0] rd_idx_p1;
  logic [DATA_W-1:0] rd_data_p1;

  // Stage p0: select index and read value ahead of the edge
  always_comb begin
    rd_idx_p0 = rd_en ? rd_reg : rd_idx_p1;
  end

  always_comb begin
    // Array read happens before the write lands, so same-edge reads see old data
    rd_val_p0 = mem[rd_idx_p0];
`ifdef REG_FILE_MP_BYPASS_EN
    if (we && (waddr == rd_idx_p0)) begin
      rd_val_p0 = wdata;
    end
`endif
    // Index 0 is hardwired zero; nothing valid is readable while clearing
    if (clear || (rd_idx_p0 == '0)) begin
      rd_val_p0 = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Stage p1: held index and registered read data
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      rd_idx_p1  <= '0;
      rd_data_p1 <= '0;
    end else begin
      rd_idx_p1  <= rd_idx_p0;
      rd_data_p1 <= rd_val_p0;
    end
  end

  assign rd_data = rd_data_p1;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with one write port. Each read port owns a
// full copy of the storage so any index combination can be read in parallel.
// After reset an INIT sweep writes zero to indices 1..depth-1, one per cycle,
// while init_busy is high; then the controller sits in RUN until reset.
// Optional macro REG_FILE_MP_BYPASS_EN: write-first forwarding on every port.
// Ports:
//   clk, resetn     : clock, asynchronous active-high reset
//   c_we, c_squashn : write request and active-low cancel
//   c_reg, c_writedatain : write index and data (index 0 is never written)
//   rd_en, rd_reg   : per-port index capture, packed ADDR_W per port
//   rd_data         : per-port read data, packed DATA_W per port
//   init_busy       : high during the post-reset clear sweep
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     c_we,
  input  logic                     c_squashn,
  input  logic [ADDR_W-1:0]        c_reg,
  input  logic [DATA_W-1:0]        c_writedatain,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_reg,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     init_busy
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] sweep_cnt, sweep_cnt_nx;

  logic              eff_we;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state     <= INIT;
      sweep_cnt <= ADDR_W'(1);
    end else begin
      state     <= state_nx;
      sweep_cnt <= sweep_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    sweep_cnt_nx = sweep_cnt;
    if (state == INIT) begin
      sweep_cnt_nx = sweep_cnt + ADDR_W'(1);
      if (sweep_cnt == {ADDR_W{1'b1}}) begin
        state_nx = RUN;
      end
    end
  end

  assign init_busy = (state == INIT);

  assign eff_we = c_we & c_squashn & (c_reg != '0) & ~init_busy;

  // While reset is held nothing is committed, so an interrupted write is lost.
  // During INIT the sweep owns the write port and user writes are dropped.
  assign bank_we    = ~resetn & (init_busy | eff_we);
  assign bank_waddr = init_busy ? sweep_cnt : c_reg;
  assign bank_wdata = init_busy ? '0 : c_writedatain;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_bank
    reg_file_mp_bank #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk    (clk),
      .resetn (resetn),
      .clear  (init_busy),
      .we     (bank_we),
      .waddr  (bank_waddr),
      .wdata  (bank_wdata),
      .rd_en  (rd_en[k]),
      .rd_reg (rd_reg[k*ADDR_W +: ADDR_W]),
      .rd_data(rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

`ifdef REG_FILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        c_we, c_squashn;
  logic [4:0]  c_reg;
  logic [31:0] c_writedatain;
  logic [1:0]  rd_en;
  logic [9:0]  rd_reg;
  logic [63:0] rd_data;
  logic        init_busy;

  logic         c_we4;
  logic         one = 1'b1;
  logic [4:0]   c_reg4;
  logic [63:0]  wdata4;
  logic [3:0]   rd_en4;
  logic [19:0]  rd_reg4;
  logic [255:0] rd_data4;
  logic         init_busy4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file_mp u_dut (
    .clk(clk), .resetn(resetn), .c_we(c_we), .c_squashn(c_squashn),
    .c_reg(c_reg), .c_writedatain(c_writedatain), .rd_en(rd_en),
    .rd_reg(rd_reg), .rd_data(rd_data), .init_busy(init_busy)
  );

  reg_file_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .c_we(c_we4), .c_squashn(one),
    .c_reg(c_reg4), .c_writedatain(wdata4), .rd_en(rd_en4),
    .rd_reg(rd_reg4), .rd_data(rd_data4), .init_busy(init_busy4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: after reset everything reads zero for depth-1 cycles
  // (the clear period) and storage is all zero afterwards; writes are
  // accepted only outside that period.
  logic [31:0] mm [32];
  logic [4:0]  m_idx [2];
  logic [31:0] m_exp [2];
  int          busy_left = 31;
  logic        m_busy, m_eff;
  logic [4:0]  m_nidx;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = '0;
      m_exp[k] = '0;
    end
  end

  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      busy_left = 31;
      for (int k = 0; k < 2; k++) begin
        m_idx[k] = '0;
        m_exp[k] = '0;
      end
      for (int i = 0; i < 32; i++) mm[i] = '0;
    end else begin
      m_busy = (busy_left > 0);
      m_eff  = !m_busy && c_we && c_squashn && (c_reg != 5'd0);
      for (int k = 0; k < 2; k++) begin
        m_nidx   = rd_en[k] ? rd_reg[k*5 +: 5] : m_idx[k];
        m_idx[k] = m_nidx;
        if (m_busy || m_nidx == 5'd0) m_exp[k] = '0;
        else if (BYP && m_eff && c_reg == m_nidx) m_exp[k] = c_writedatain;
        else m_exp[k] = mm[m_nidx];
      end
      if (m_eff) mm[c_reg] = c_writedatain;
      if (m_busy) busy_left--;
    end
  end

  always @(negedge clk) begin
    chk("mdl_busy", 64'(init_busy), 64'(busy_left > 0));
    for (int k = 0; k < 2; k++) begin
      chk("mdl_rd", 64'(rd_data[k*32 +: 32]), 64'(m_exp[k]));
    end
  end

  function automatic logic [31:0] port(input int k);
    return rd_data[k*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    c_we = 1'b1; c_reg = a; c_writedatain = d;
    step();
    c_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_en = 2'b11; rd_reg = {a1, a0};
    step();
    rd_en = 2'b00;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (init_busy && n < 40) begin
      step();
      n++;
    end
    chk(name, 64'(n), 64'd31);
  endtask

  initial begin
    resetn = 1'b1;
    c_we = 1'b0; c_squashn = 1'b1; c_reg = '0; c_writedatain = '0;
    rd_en = '0; rd_reg = '0;
    c_we4 = 1'b0; c_reg4 = '0; wdata4 = '0; rd_en4 = '0; rd_reg4 = '0;
    step(); step();
    chk("rst_busy", 64'(init_busy), 64'd1);
    chk("rst_rd", rd_data, 64'd0);

    resetn = 1'b0;
    wait_init("init_len");
    chk("init4_done", 64'(init_busy4), 64'd0);
    for (int i = 0; i < 16; i++) begin
      rd(5'(i), 5'(i + 16));
      chk("clear_p0", 64'(port(0)), 64'd0);
      chk("clear_p1", 64'(port(1)), 64'd0);
    end

    wr(5'd7, 32'hDEADBEEF);
    rd(5'd7, 5'd7);
    chk("r7_p0", 64'(port(0)), 64'hDEADBEEF);
    chk("r7_p1", 64'(port(1)), 64'hDEADBEEF);

    wr(5'd0, 32'h1234);
    rd(5'd0, 5'd0);
    chk("r0_zero", rd_data, 64'd0);
    c_we = 1'b1; c_squashn = 1'b0; c_reg = 5'd3; c_writedatain = 32'h999;
    step();
    c_we = 1'b0; c_squashn = 1'b1;
    rd(5'd3, 5'd3);
    chk("squash_r3", 64'(port(0)), 64'd0);

    rd(5'd5, 5'd7);
    chk("hold_p0", 64'(port(0)), 64'd0);
    chk("hold_p1", 64'(port(1)), 64'hDEADBEEF);
    wr(5'd5, 32'h55);
    chk("held_same", 64'(port(0)), BYP ? 64'h55 : 64'd0);
    step();
    chk("held_next", 64'(port(0)), 64'h55);
    chk("held_p1", 64'(port(1)), 64'hDEADBEEF);

    rd_en = 2'b01; rd_reg = {5'd7, 5'd5};
    c_we = 1'b1; c_reg = 5'd5; c_writedatain = 32'hAA;
    step();
    c_we = 1'b0; rd_en = 2'b00;
    chk("cap_wr_same", 64'(port(0)), BYP ? 64'hAA : 64'h55);
    step();
    chk("cap_wr_next", 64'(port(0)), 64'hAA);

    // Four independent ports on the wide instance
    for (int i = 0; i < 4; i++) begin
      c_we4 = 1'b1;
      c_reg4 = (i == 0) ? 5'd3 : (i == 1) ? 5'd10 : (i == 2) ? 5'd17 : 5'd30;
      wdata4 = 64'h1111_2222_3333_0000 + 64'(i) + (64'(i) << 60);
      step();
    end
    c_we4 = 1'b0;
    rd_en4 = 4'hF; rd_reg4 = {5'd30, 5'd17, 5'd10, 5'd3};
    step();
    chk("w4_p0", rd_data4[0*64 +: 64], 64'h1111_2222_3333_0000);
    chk("w4_p1", rd_data4[1*64 +: 64], 64'h2111_2222_3333_0001);
    chk("w4_p2", rd_data4[2*64 +: 64], 64'h3111_2222_3333_0002);
    chk("w4_p3", rd_data4[3*64 +: 64], 64'h4111_2222_3333_0003);
    rd_reg4 = {5'd3, 5'd0, 5'd30, 5'd10};
    step();
    rd_en4 = 4'h0;
    chk("w4b_p0", rd_data4[0*64 +: 64], 64'h2111_2222_3333_0001);
    chk("w4b_p1", rd_data4[1*64 +: 64], 64'h4111_2222_3333_0003);
    chk("w4b_p2", rd_data4[2*64 +: 64], 64'd0);
    chk("w4b_p3", rd_data4[3*64 +: 64], 64'h1111_2222_3333_0000);

    // Reset in RUN, then again in the middle of the sweep
    wr(5'd20, 32'h77);
    wr(5'd31, 32'h31313131);
    wr(5'd1, 32'h11);
    rd(5'd20, 5'd31);
    chk("r20_set", 64'(port(0)), 64'h77);
    chk("r31_set", 64'(port(1)), 64'h31313131);
    #1 resetn = 1'b1;
    #1;
    chk("async_rd", rd_data, 64'd0);
    chk("async_busy", 64'(init_busy), 64'd1);
    step();
    resetn = 1'b0;
    for (int i = 0; i < 11; i++) step();
    c_we = 1'b1; c_reg = 5'd20; c_writedatain = 32'h66;
    rd_en = 2'b10; rd_reg = {5'd20, 5'd0};
    step();
    c_we = 1'b0; rd_en = 2'b00;
    chk("mid_busy", 64'(init_busy), 64'd1);
    #1 resetn = 1'b1;
    step();
    resetn = 1'b0;
    c_we = 1'b1; c_reg = 5'd9; c_writedatain = 32'h99;
    wait_init("reinit_len");
    c_we = 1'b0;
    rd(5'd20, 5'd31);
    chk("r20_clr", 64'(port(0)), 64'd0);
    chk("r31_clr", 64'(port(1)), 64'd0);
    rd(5'd1, 5'd9);
    chk("r1_clr", 64'(port(0)), 64'd0);
    chk("r9_ign", 64'(port(1)), 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..8).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port c_we  input  1  write request.
REQ-007 SHALL have port c_squashn  input  1  write squash, active-low; 0 cancels the write.
REQ-008 SHALL have port c_reg  input  ADDR_W  write index.
REQ-009 SHALL have port c_writedatain  input  DATA_W  write data.
REQ-010 SHALL have port rd_en  input  NUM_RD  per-port read enable (address capture).
REQ-011 SHALL have port rd_reg  input  NUM_RD*ADDR_W  packed read indices, port k at [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W].
REQ-013 SHALL have port init_busy  output  1  high while the post-reset clear sweep runs.

Function
REQ-014 Effective write SHALL be c_we & c_squashn & (c_reg != 0) & !init_busy; committed to all NUM_RD bank copies at the same edge.
REQ-015 Register 0 SHALL never be written and SHALL always read as zero.
REQ-016 Read latency SHALL be 1 cycle: rd_en[k]=1 at edge N captures rd_reg[k]; rd_data[k] shows that register after edge N.
REQ-017 With rd_en[k]=0, port k SHALL keep its last captured index and re-read it every cycle, so a write to that index appears on rd_data[k] one cycle after commit.
REQ-018 Read ports SHALL be fully independent; any combination of indices, including all equal, SHALL be legal.
REQ-019 Same-edge read capture and write to the same index SHALL return old data (bypass behaviour per REQ-027).
REQ-020 FSM states SHALL be INIT and RUN; reset enters INIT.
REQ-021 INIT SHALL write zero to indices 1..depth-1 in ascending order, one per cycle, via an ADDR_W-bit sweep counter; after writing index depth-1 go to RUN (init_busy high exactly depth-1 cycles after reset release).
REQ-022 During INIT, c_we SHALL be ignored, rd_en captures SHALL still update held indices, and rd_data SHALL be all zeros.
REQ-023 RUN SHALL be absorbing until next reset.

Reset
REQ-024 Asserting resetn SHALL asynchronously force: FSM=INIT, sweep counter=1, init_busy=1, all held read indices=0, rd_data=0.
REQ-025 Reset asserted mid-sweep or mid-write SHALL restart the sweep from index 1; the interrupted write is lost.
REQ-026 Storage array itself SHALL NOT be reset directly; clearing relies solely on the INIT sweep.

Configuration
REQ-027 With macro REG_FILE_MP_BYPASS_EN defined, a read of index i (capture or held) in the same cycle as an effective write to i SHALL return c_writedatain (write-first forwarding, per port); without it, old data is returned (REQ-019).

Structure
REQ-028 Package reg_file_mp_pkg SHALL hold default DATA_W/ADDR_W/NUM_RD constants and the FSM state enum (INIT, RUN).
REQ-029 One sub-module reg_file_mp_bank (one write port, one read port with held index, optional bypass) SHALL be instantiated NUM_RD times by generate.

Verification
REQ-030 Reset release -> init_busy high 31 cycles (ADDR_W=5), then low; read of every index returns 0.
REQ-031 Write 0xDEADBEEF to r7, next cycle rd_en=2'b11, rd_reg={r7,r7} -> both ports 0xDEADBEEF one cycle later.
REQ-032 c_we=1, c_reg=0, data 0x1234 -> r0 reads 0; c_we=1, c_squashn=0 to r3 -> r3 unchanged.
REQ-033 Port 0 holds r5 (rd_en=0), write 0x55 to r5 -> rd_data[0] becomes 0x55 one cycle after commit; with REG_FILE_MP_BYPASS_EN, same-cycle capture/write of r5=0xAA returns 0xAA, without it returns old value.
REQ-034 Reset asserted at sweep index 12 after writing r20=0x77 -> sweep restarts at 1, full 31-cycle init, r20 reads 0.
REQ-035 NUM_RD=4, DATA_W=64: four distinct indices read in one cycle -> each port returns its own register, no cross-port interference.
